// File: rtl/rgb_pkg.sv
// Shared types and helpers for the RGB LED sequencer.
package rgb_pkg;

  typedef enum logic [1:0] {
    RED   = 2'd0,
    GREEN = 2'd1,
    BLUE  = 2'd2,
    WHITE = 2'd3
  } color_t;

  localparam int NUM_COLORS = 4;

  // Channel mask per colour: bit0=red, bit1=green, bit2=blue.
  function automatic logic [2:0] color_mask(input color_t c);
    logic [2:0] m;
    case (c)
      RED:     m = 3'b001;
      GREEN:   m = 3'b010;
      BLUE:    m = 3'b100;
      WHITE:   m = 3'b111;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

  // Next colour in the wrap-around sequence RED->GREEN->BLUE->WHITE->RED.
  function automatic color_t next_color(input color_t c);
    color_t n;
    case (c)
      RED:     n = GREEN;
      GREEN:   n = BLUE;
      BLUE:    n = WHITE;
      WHITE:   n = RED;
      default: n = RED;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/rgb_sequencer_if.sv
// Bus between the button edge detectors / brightness source and the LED sequencer.
interface rgb_sequencer_if #(
  parameter int PWM_BITS = 8
);
  logic                  step;
  logic                  mode;
  logic [PWM_BITS-1:0]   duty;
  logic [2:0]            rgb;
  rgb_pkg::color_t       color;
  logic                  auto_on;

  // Upstream side: issues pulses and brightness, observes LED state.
  modport master (
    output step, mode, duty,
    input  rgb, color, auto_on
  );

  // Sequencer side.
  modport slave (
    input  step, mode, duty,
    output rgb, color, auto_on
  );
endinterface

// File: rtl/rgb_sequencer_pwm_gen.sv
// Free-running PWM generator; duty is only taken at the period wrap so a
// brightness change never cuts a period short.
module pwm_gen #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] i_duty,
  output logic                o_pwm_on
);

  localparam logic [PWM_BITS-1:0] CNT_LAST = {PWM_BITS{1'b1}};

  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [PWM_BITS-1:0] r_duty_q;

  // Period counter and wrap-synchronous duty capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pwm_cnt <= '0;
      r_duty_q  <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
      if (r_pwm_cnt == CNT_LAST) begin
        r_duty_q <= i_duty;
      end else begin
        r_duty_q <= r_duty_q;
      end
    end
  end

  // Strict less-than: duty of all ones is 2^N-1 on-cycles, never full on.
  assign o_pwm_on = (r_pwm_cnt < r_duty_q);

endmodule

// File: rtl/rgb_sequencer.sv
// RGB LED controller: colour FSM advanced by manual step or auto timer,
// globally dimmed by a single PWM gate, registered LED drive.
module rgb_sequencer
  import rgb_pkg::*;
#(
  parameter int AUTO_PERIOD = 12_000_000,
  parameter int PWM_BITS    = 8
) (
  input  logic             clk,
  input  logic             rst,
  rgb_sequencer_if.slave   bus
);

  localparam int                 TIMER_W    = (AUTO_PERIOD > 2) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(AUTO_PERIOD - 1);

  color_t             r_color;
  logic               r_auto_on;
  logic [TIMER_W-1:0] r_timer;
  logic [2:0]         r_rgb;

  logic w_expire;
  logic w_advance;
  logic w_timer_clr;
  logic w_pwm_on;

  // A step and a timer expiry in the same cycle merge into one advance.
  assign w_expire    = r_auto_on && (r_timer == TIMER_LAST);
  assign w_advance   = bus.step || w_expire;
  assign w_timer_clr = bus.mode || w_advance || !r_auto_on;

  pwm_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clk      (clk),
    .rst      (rst),
    .i_duty   (bus.duty),
    .o_pwm_on (w_pwm_on)
  );

  // Colour FSM, mode flag, auto-advance timer and registered LED drive.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_color   <= RED;
      r_auto_on <= 1'b0;
      r_timer   <= '0;
      r_rgb     <= 3'b000;
    end else begin
      if (w_advance) begin
        r_color <= next_color(r_color);
      end else begin
        r_color <= r_color;
      end

      if (bus.mode) begin
        r_auto_on <= ~r_auto_on;
      end else begin
        r_auto_on <= r_auto_on;
      end

      if (w_timer_clr) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + TIMER_W'(1);
      end

      // One PWM gate for all channels keeps the mixed colours skew-free.
      r_rgb <= color_mask(r_color) & {3{w_pwm_on}};
    end
  end

  assign bus.color   = r_color;
  assign bus.auto_on = r_auto_on;
  assign bus.rgb     = r_rgb;

endmodule

// File: tb/tb_rgb_sequencer.sv
// Directed self-checking bench for rgb_sequencer (AUTO_PERIOD=16, PWM_BITS=8).
module tb_rgb_sequencer;

  logic clk;
  logic rst_n;
  int   assert_cnt;
  int   fail_cnt;
  int   n;       // posedges since the last reset release
  int   base;    // edge index of the mode pulse cycle in the AUTO phase
  int   ons;
  int   bad;

  rgb_sequencer_if #(.PWM_BITS(8)) bus ();

  rgb_sequencer #(
    .AUTO_PERIOD (16),
    .PWM_BITS    (8)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    n = n + 1;
  endtask

  task automatic run_to(input int c);
    while ((n - base) < c) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    assert_cnt = assert_cnt + 1;
    assert (obs === exp_v) else begin
      fail_cnt = fail_cnt + 1;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Counts cycles with the LED lit and cycles where the lit pattern is not the mask.
  task automatic count_on(input int cycles, input logic [2:0] mask, output int on_c, output int bad_c);
    on_c  = 0;
    bad_c = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.rgb !== 3'b000) begin
        on_c = on_c + 1;
        if (bus.rgb !== mask) bad_c = bad_c + 1;
      end
    end
  endtask

  initial begin
    logic [2:0] masks [4];
    logic [1:0] cols  [4];
    masks[0] = 3'b010; masks[1] = 3'b100; masks[2] = 3'b111; masks[3] = 3'b001;
    cols[0]  = 2'd1;   cols[1]  = 2'd2;   cols[2]  = 2'd3;   cols[3]  = 2'd0;
    assert_cnt = 0;
    fail_cnt   = 0;
    n          = 0;
    base       = 0;
    rst_n      = 1'b0;
    bus.step   = 1'b0;
    bus.mode   = 1'b0;
    bus.duty   = 8'd128;

    // Reset held across clock edges.
    repeat (3) @(posedge clk);
    #1;
    check("reset_color", 32'(bus.color), 32'd0);
    check("reset_auto", 32'(bus.auto_on), 32'd0);
    check("reset_rgb", 32'(bus.rgb), 32'd0);

    // Power-on: dark for the first period, then 128/256 red.
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    count_on(256, 3'b001, ons, bad);
    check("pwr_win0_on", 32'(ons), 32'd0);
    for (int w = 1; w < 4; w++) begin
      count_on(256, 3'b001, ons, bad);
      check($sformatf("pwr_win%0d_on", w), 32'(ons), 32'd128);
      check($sformatf("pwr_win%0d_mask", w), 32'(bad), 32'd0);
    end
    check("pwr_color", 32'(bus.color), 32'd0);

    // Manual steps, 10 cycles apart.
    for (int i = 0; i < 4; i++) begin
      bus.step = 1'b1;
      tick();
      bus.step = 1'b0;
      check($sformatf("step%0d_color", i), 32'(bus.color), 32'(cols[i]));
      tick();
      check($sformatf("step%0d_rgb", i), 32'(bus.rgb), 32'(masks[i]));
      repeat (8) tick();
    end

    // AUTO mode; cycle 0 is the mode pulse cycle.
    base = n;
    bus.mode = 1'b1;
    tick();
    bus.mode = 1'b0;
    check("auto_on_c1", 32'(bus.auto_on), 32'd1);
    check("auto_c1_color", 32'(bus.color), 32'd0);
    run_to(16); check("auto_c16", 32'(bus.color), 32'd0);
    run_to(17); check("auto_c17", 32'(bus.color), 32'd1);
    run_to(25); check("auto_c25", 32'(bus.color), 32'd1);
    bus.step = 1'b1;
    run_to(26);
    bus.step = 1'b0;
    check("auto_step_c26", 32'(bus.color), 32'd2);
    run_to(41); check("auto_c41", 32'(bus.color), 32'd2);
    run_to(42); check("auto_c42", 32'(bus.color), 32'd3);
    // Step coincides with timer==15: single advance, timer restarts.
    run_to(57);
    bus.step = 1'b1;
    run_to(58);
    bus.step = 1'b0;
    check("coinc_c58", 32'(bus.color), 32'd0);
    run_to(73); check("coinc_c73", 32'(bus.color), 32'd0);
    run_to(74); check("coinc_c74", 32'(bus.color), 32'd1);
    run_to(219);
    check("pre_rst_color", 32'(bus.color), 32'd2);
    check("pre_rst_rgb", 32'(bus.rgb), 32'd4);
    check("pre_rst_auto", 32'(bus.auto_on), 32'd1);

    // Asynchronous reset between edges.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_color", 32'(bus.color), 32'd0);
    check("arst_auto", 32'(bus.auto_on), 32'd0);
    check("arst_rgb", 32'(bus.rgb), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    count_on(256, 3'b001, ons, bad);
    check("rel_win0_on", 32'(ons), 32'd0);
    count_on(256, 3'b001, ons, bad);
    check("rel_win1_on", 32'(ons), 32'd128);
    check("rel_win1_mask", 32'(bad), 32'd0);
    check("rel_color", 32'(bus.color), 32'd0);
    check("rel_auto", 32'(bus.auto_on), 32'd0);

    // Duty 200 captured at edge 768; switched to 20 mid-period (pwm_cnt=50).
    bus.duty = 8'd200;
    while (n < 768) tick();
    ons = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (bus.rgb !== 3'b000) ons = ons + 1;
      if (n == 818) bus.duty = 8'd20;
    end
    check("duty200_period", 32'(ons), 32'd200);
    count_on(256, 3'b001, ons, bad);
    check("duty20_period", 32'(ons), 32'd20);
    bus.duty = 8'd0;
    count_on(256, 3'b001, ons, bad);
    check("duty20_tail", 32'(ons), 32'd20);
    count_on(512, 3'b001, ons, bad);
    check("duty0_dark", 32'(ons), 32'd0);

    // mode and step together: advance and toggle.
    bus.step = 1'b1;
    bus.mode = 1'b1;
    tick();
    bus.step = 1'b0;
    bus.mode = 1'b0;
    check("ms_color", 32'(bus.color), 32'd1);
    check("ms_auto", 32'(bus.auto_on), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/rgb_sequencer.md
Name: rgb_sequencer

Overview:
- Controller for the board RGB LED.
- Holds the current colour state and advances it from one of two sources: a manual step pulse (from the edgedetect on the button), or an internal auto-advance timer.
- Applies global PWM brightness to the selected channels.
- Sits between the button edge detectors and the rgb[2:0] pins; it is the only driver of the LED.

Parameters:
AUTO_PERIOD, 12_000_000, clock cycles between automatic colour advances (1 s at 12 MHz); must be >= 2
PWM_BITS, 8, width of PWM counter and duty input

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
step  input  1  single-cycle pulse: advance colour by one
mode  input  1  single-cycle pulse: toggle MANUAL/AUTO
duty  input  PWM_BITS  brightness, on-time = duty / 2^PWM_BITS
rgb  output  3  LED drive, bit0=red, bit1=green, bit2=blue; 1 = on
color  output  2  current colour state (color_t encoding)
auto_on  output  1  1 while in AUTO mode

Behaviour:
- Reset (rst low, asynchronous): color=RED (2'd0), auto_on=0, timer=0, pwm_cnt=0, duty_q=0, rgb=3'b000. Outputs stay at these values while rst is low.
- Colour FSM, 4 states, wraps: RED(0) -> GREEN(1) -> BLUE(2) -> WHITE(3) -> RED.
- Channel mask per state: RED=001, GREEN=010, BLUE=100, WHITE=111.
- Advance event = step, or (auto_on and timer == AUTO_PERIOD-1). The colour changes on the clock edge following the event cycle.
- Exactly one advance per cycle. step coinciding with timer expiry advances once, not twice.
- Timer behaviour:
  - Counts only while auto_on=1.
  - Resets to 0 on any advance event (manual or timed), so a manual step in AUTO restarts the full period.
  - Held at 0 while auto_on=0.
- Mode pulse toggles auto_on and clears the timer.
  - mode and step in the same cycle: the colour advances and the mode toggles; timer=0.
  - Entering AUTO: first timed advance occurs AUTO_PERIOD cycles after the mode pulse cycle.
- PWM:
  - pwm_cnt is free-running modulo 2^PWM_BITS and runs in both modes.
  - duty is sampled into duty_q only when pwm_cnt == 2^PWM_BITS-1, so a duty change never truncates a period.
  - pwm_on = (pwm_cnt < duty_q), unsigned compare.
  - duty=0 gives always off. duty=2^PWM_BITS-1 gives on for 255 of 256 cycles; full-on is not reachable by design.
- rgb is registered: rgb <= mask(color) & {3{pwm_on}}. One cycle latency from pwm_cnt/colour to pins. The same pwm_on gates all channels, so no colour skew.
- color and auto_on are direct register outputs, no added latency.
- Reset asserted mid-period: all state clears immediately. After release, the LED stays dark until the first duty_q sample, which occurs 2^PWM_BITS cycles after reset release.
- step and mode are assumed single-cycle. A level held high advances every cycle; debouncing/edge detection is upstream.

Decomposition:
- Package rgb_pkg:
  - enum color_t {RED=2'd0, GREEN=2'd1, BLUE=2'd2, WHITE=2'd3}
  - function color_mask(color_t) returning the 3-bit channel mask
  - constant NUM_COLORS=4
- Sub-module pwm_gen:
  - parameter PWM_BITS
  - ports clk, rst, duty in, pwm_on out
  - contains pwm_cnt and duty_q with the wrap-sample rule
- rgb_sequencer holds the colour FSM, mode flag, timer and output register.

Test Plan:
- Reset then duty=8'd128, manual mode, no pulses, 1024 cycles -> color=0. rgb=001 for exactly 128 of each 256-cycle window after the first sample; rgb=000 for the first 256 cycles.
- Four step pulses spaced 10 cycles -> color sequence 1,2,3,0 each one cycle after its pulse. rgb mask while PWM is on: 010, 100, 111, 001.
- AUTO_PERIOD=16, mode pulse at cycle 0 -> auto_on=1 at cycle 1. color advances at cycles 17, 33, 49. A step at cycle 25 advances immediately; the next timed advance is at cycle 42.
- AUTO_PERIOD=16, step asserted in the same cycle as timer==15 -> color increments by exactly 1 and timer=0.
- Change duty 200 -> 20 mid-period (pwm_cnt=50) -> the current period still shows 200 on-cycles. The next period shows 20 on-cycles. duty=0 -> rgb stays 000 for 512 cycles.
- rst pulled low asynchronously between clock edges while in AUTO, color=2 -> color=0, auto_on=0, rgb=000 immediately without a clock edge. After release, behaviour is identical to power-on.
